// File: rtl/prog_toggle_divider_if.sv
// rtl/prog_toggle_divider_if.sv - control/status bundle for the programmable toggle divider (TICK_COUNT_EN adds tick counter signals)
interface prog_toggle_divider_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             mode;
  logic             tc_load;
  logic [WIDTH-1:0] tc_in;
  logic             tc_pending;
  logic [WIDTH-1:0] active_tc;
  logic [WIDTH-1:0] counts_var;
  logic [WIDTH-1:0] next_counts_var;
  logic             tick;
  logic             out;
`ifdef TICK_COUNT_EN
  logic             tick_clr;
  logic [15:0]      tick_cnt;
`endif

  modport master (
    output en, mode, tc_load, tc_in,
`ifdef TICK_COUNT_EN
    output tick_clr,
    input  tick_cnt,
`endif
    input  tc_pending, active_tc, counts_var, next_counts_var, tick, out
  );

  modport slave (
    input  en, mode, tc_load, tc_in,
`ifdef TICK_COUNT_EN
    input  tick_clr,
    output tick_cnt,
`endif
    output tc_pending, active_tc, counts_var, next_counts_var, tick, out
  );
endinterface

// File: rtl/prog_toggle_divider.sv
// rtl/prog_toggle_divider.sv - programmable wrap counter driving a toggle or pulse output; TICK_COUNT_EN adds a saturating tick counter
module prog_toggle_divider #(
  parameter int WIDTH      = 5,
  parameter int DEFAULT_TC = 31
) (
  input logic                  clk,
  input logic                  rst_n,
  prog_toggle_divider_if.slave bus
);
  localparam logic [WIDTH-1:0] RESET_TC = WIDTH'(DEFAULT_TC);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] active_tc;
  logic [WIDTH-1:0] shadow_tc;
  logic             pending;
  logic             out_q;
  logic             at_tc;
  logic             tick;

  always_comb begin
    at_tc     = (count == active_tc);
    tick      = bus.en && at_tc;
    count_nxt = count;
    if (bus.en) begin
      count_nxt = at_tc ? '0 : count + WIDTH'(1);
    end
  end

  assign bus.tick            = tick;
  assign bus.next_counts_var = count_nxt;
  assign bus.counts_var      = count;
  assign bus.active_tc       = active_tc;
  assign bus.tc_pending      = pending;
  assign bus.out             = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      out_q     <= 1'b0;
      active_tc <= RESET_TC;
      shadow_tc <= RESET_TC;
      pending   <= 1'b0;
    end else begin
      count <= count_nxt;
      if (bus.en) begin
        out_q <= bus.mode ? tick : (out_q ^ tick);
      end
      // Commit uses the old shadow; a load on the same edge re-arms pending.
      if (tick && pending) begin
        active_tc <= shadow_tc;
        pending   <= 1'b0;
      end
      if (bus.tc_load) begin
        shadow_tc <= bus.tc_in;
        pending   <= 1'b1;
      end
    end
  end

`ifdef TICK_COUNT_EN
  logic [15:0] tick_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (bus.tick_clr) begin
      tick_cnt <= '0;
    end else if (tick && (tick_cnt != 16'hFFFF)) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign bus.tick_cnt = tick_cnt;
`endif
endmodule

// File: tb/tb_prog_toggle_divider.sv
// tb/tb_prog_toggle_divider.sv - randomized bench with an integer reference model for prog_toggle_divider
module tb_prog_toggle_divider;
  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_toggle_divider_if #(.WIDTH(W)) bus ();
  prog_toggle_divider #(.WIDTH(W), .DEFAULT_TC(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  int m_count, m_tc, m_shadow, m_tcnt;
  bit m_pending, m_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_tc = 31; m_shadow = 31; m_pending = 0; m_out = 0; m_tcnt = 0;
  endtask

  // Reference: the period is TC+1 cycles; a wrap is the cycle the count equals TC.
  task automatic model_step();
    bit tk;
    bit clr;
    tk = bus.en && (m_count == m_tc);
    clr = 0;
`ifdef TICK_COUNT_EN
    clr = bus.tick_clr;
`endif
    if (clr) m_tcnt = 0;
    else if (tk && m_tcnt < 65535) m_tcnt = m_tcnt + 1;
    if (bus.en) begin
      m_out = bus.mode ? tk : (m_out ^ tk);
      if (tk) begin
        m_count = 0;
        if (m_pending) begin
          m_tc = m_shadow;
          m_pending = 0;
        end
      end else begin
        m_count = (m_count + 1) % (MAX + 1);
      end
    end
    if (bus.tc_load) begin
      m_shadow = int'(bus.tc_in);
      m_pending = 1;
    end
  endtask

  task automatic check_regs();
    check("count", 32'(bus.counts_var), m_count);
    check("out", 32'(bus.out), 32'(m_out));
    check("active_tc", 32'(bus.active_tc), m_tc);
    check("tc_pending", 32'(bus.tc_pending), 32'(m_pending));
`ifdef TICK_COUNT_EN
    check("tick_cnt", 32'(bus.tick_cnt), m_tcnt);
`endif
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    bit tk;
    int nxt;
    #1;
    tk = bus.en && (m_count == m_tc);
    nxt = !bus.en ? m_count : (tk ? 0 : (m_count + 1) % (MAX + 1));
    check("tick", 32'(bus.tick), 32'(tk));
    check("next_counts_var", 32'(bus.next_counts_var), nxt);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
    bus.tc_load = 1'b0;
`ifdef TICK_COUNT_EN
    bus.tick_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.tc_load = 1'b0; bus.tc_in = '0;
`ifdef TICK_COUNT_EN
    bus.tick_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_regs();
  endtask

  task automatic run_until_count(input int target);
    int guard;
    guard = 0;
    while (m_count != target && guard < 200) begin
      cycle();
      guard++;
    end
    if (m_count != target) check("wait_count_timeout", 32'(m_count), target);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Default TC=31, toggle mode: period 64
    bus.en = 1'b1;
    repeat (32) cycle();
    check("t1_out_high", 32'(bus.out), 1);
    repeat (32) cycle();
    check("t1_out_low", 32'(bus.out), 0);

    // Pulse mode with a TC load mid-period
    do_reset();
    bus.en = 1'b1; bus.mode = 1'b1;
    repeat (10) cycle();
    bus.tc_load = 1'b1; bus.tc_in = 5'd4;
    cycle();
    check("t2_pending", 32'(bus.tc_pending), 1);
    run_until_count(0);
    check("t2_active_tc", 32'(bus.active_tc), 4);
    repeat (15) cycle();

    // Load on the commit edge: old shadow commits, new one stays pending
    bus.tc_load = 1'b1; bus.tc_in = 5'd9;
    cycle();
    run_until_count(m_tc);
    bus.tc_load = 1'b1; bus.tc_in = 5'd7;
    cycle();
    check("t3_active_tc", 32'(bus.active_tc), 9);
    check("t3_pending", 32'(bus.tc_pending), 1);
    run_until_count(m_tc);
    cycle();
    check("t3_commit7", 32'(bus.active_tc), 7);

    // Freeze at count 12
    do_reset();
    bus.en = 1'b1;
    run_until_count(12);
    bus.en = 1'b0;
    repeat (10) cycle();
    check("t4_hold", 32'(bus.counts_var), 12);
    check("t4_next", 32'(bus.next_counts_var), 12);
    bus.en = 1'b1;
    cycle();
    check("t4_resume", 32'(bus.counts_var), 13);

    // TC=0 toggles every cycle, then async reset with no clock edge
    bus.tc_load = 1'b1; bus.tc_in = '0;
    cycle();
    run_until_count(0);
    repeat (6) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_count", 32'(bus.counts_var), 0);
    check("t5_async_out", 32'(bus.out), 0);
    check("t5_async_tc", 32'(bus.active_tc), 31);
    check("t5_async_pending", 32'(bus.tc_pending), 0);
    @(negedge clk);
    do_reset();

    // Full-range wrap plus randomized traffic
    bus.en = 1'b1;
    run_until_count(31);
    cycle();
    check("full_wrap", 32'(bus.counts_var), 0);
    for (int i = 0; i < 1500; i++) begin
      bus.en = ($urandom_range(0, 99) < 85);
      if (i % 50 == 0) bus.mode = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 5) begin
        bus.tc_load = 1'b1;
        r = $urandom_range(0, 9);
        bus.tc_in = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : W'($urandom_range(0, 12));
      end
`ifdef TICK_COUNT_EN
      bus.tick_clr = ($urandom_range(0, 99) < 2);
`endif
      cycle();
    end

`ifdef TICK_COUNT_EN
    // Saturation with TC=0
    do_reset();
    bus.en = 1'b1; bus.mode = 1'b0; bus.tc_load = 1'b1; bus.tc_in = '0;
    cycle();
    run_until_count(0);
    repeat (66000) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check_regs();
    check("t6_saturated", 32'(bus.tick_cnt), 32'hFFFF);
    bus.tick_clr = 1'b1;
    cycle();
    check("t6_clr_prio", 32'(bus.tick_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
